// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation codes,
// default latencies and a helper used by the controller and hazard unit.
package mdu_pkg;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } op_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with private HI/LO registers. Results are computed at
// issue and held in pend_hi/pend_lo until the busy counter expires.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] RD
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
  logic [31:0]        dvs_u, quo_u, rem_u;
  logic               div_zero;
  logic               unused_div;

  // Arithmetic results; divisors are forced to 1 on B=0 so no X is produced.
  // Signed division runs at 33 bits so -2^31 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    prod_s     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u     = $unsigned({32'd0, A}) * $unsigned({32'd0, B});
    div_zero   = (B == 32'd0);
    dvd_s      = $signed({A[31], A});
    dvs_s      = div_zero ? 33'sd1 : $signed({B[31], B});
    quo_s      = dvd_s / dvs_s;
    rem_s      = dvd_s % dvs_s;
    dvs_u      = div_zero ? 32'd1 : B;
    quo_u      = A / dvs_u;
    rem_u      = A % dvs_u;
    unused_div = quo_s[32] ^ rem_s[32];
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (start && is_muldiv(op)) begin
      case (op)
        OP_MULT: begin
          pend_hi_d = prod_s[63:32];
          pend_lo_d = prod_s[31:0];
          cnt_d     = MULT_LOAD;
        end
        OP_MULTU: begin
          pend_hi_d = prod_u[63:32];
          pend_lo_d = prod_u[31:0];
          cnt_d     = MULT_LOAD;
        end
        OP_DIV: begin
          // A zero divisor re-commits the current HI/LO, leaving them unchanged.
          pend_hi_d = div_zero ? hi_q : rem_s[31:0];
          pend_lo_d = div_zero ? lo_q : quo_s[31:0];
          cnt_d     = DIV_LOAD;
        end
        default: begin
          pend_hi_d = div_zero ? hi_q : rem_u;
          pend_lo_d = div_zero ? lo_q : quo_u;
          cnt_d     = DIV_LOAD;
        end
      endcase
    end else if (op == OP_MTHI) begin
      hi_d = A;
    end else if (op == OP_MTLO) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    busy = (cnt_q != '0);
    HI   = hi_q;
    LO   = lo_q;
    case (op)
      OP_MFHI: RD = hi_q;
      OP_MFLO: RD = lo_q;
      default: RD = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Directed and randomized bench for mdu, checked against a 64-bit integer
// reference of the multiply/divide rules and a model of HI/LO.
module tb_mdu;
  import mdu_pkg::*;

  localparam int NM = MDU_MULT_CYCLES;
  localparam int ND = MDU_DIV_CYCLES;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, RD;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .RD(RD)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // {HI,LO} after an operation, from sign/magnitude integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] old);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIVU: begin
        if (b == 32'd0) return old;
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        return {r[31:0], q[31:0]};
      end
      OP_DIV: begin
        if (b == 32'd0) return old;
        q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
        if ((sa < 0) != (sb < 0)) q = -q;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      default: return old;
    endcase
  endfunction

  // Issue one mult/div, check busy cycle by cycle, then the committed result.
  task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    logic [63:0] exp;
    int          n;
    exp   = ref_md(o, a, b, {m_hi, m_lo});
    n     = (o == OP_MULT || o == OP_MULTU) ? NM : ND;
    start = 1'b1; op = o; A = a; B = b;
    step();
    start = 1'b0; op = OP_NONE; A = $urandom; B = $urandom;
    for (int i = 1; i <= n; i++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " hi hold"}, HI, m_hi);
      chk({tag, " lo hold"}, LO, m_lo);
      if (inject && i == 2) begin
        start = 1'b1; op = OP_DIV; A = 32'd100; B = 32'd7;
      end else if (inject && i == 3) begin
        start = 1'b0; op = OP_MTLO; A = 32'hDEADBEEF;
      end else begin
        start = 1'b0; op = OP_NONE;
      end
      step();
    end
    start = 1'b0; op = OP_NONE;
    m_hi  = exp[63:32];
    m_lo  = exp[31:0];
    chk({tag, " busy done"}, 32'(busy), 32'd0);
    chk({tag, " hi"}, HI, m_hi);
    chk({tag, " lo"}, LO, m_lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          sel;

    reset = 1'b1; start = 1'b0; op = OP_NONE; A = 32'd0; B = 32'd0;
    step();
    step();
    reset = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset hi", HI, 32'd0);
    chk("reset lo", LO, 32'd0);
    chk("reset rd", RD, 32'd0);
    op = OP_MFHI; #1;
    chk("reset mfhi", RD, 32'd0);
    op = OP_NONE;

    run_md("mult", OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
    chk("mult hi lit", HI, 32'hFFFFFFFF);
    chk("mult lo lit", LO, 32'hFFFFFFF1);
    run_md("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu hi lit", HI, 32'h00000001);
    chk("multu lo lit", LO, 32'hFFFFFFFE);
    run_md("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div hi lit", HI, 32'hFFFFFFFF);
    chk("div lo lit", LO, 32'hFFFFFFFD);
    run_md("divu", OP_DIVU, 32'd7, 32'd2, 1'b0);
    chk("divu hi lit", HI, 32'd1);
    chk("divu lo lit", LO, 32'd3);
    run_md("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_md("div neg", OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0);

    // MTHI/MTLO land at the edge; no same-cycle bypass onto HI or RD.
    op = OP_MTHI; A = 32'h12345678; #1;
    chk("mthi no bypass", HI, m_hi);
    chk("rd during mthi", RD, 32'd0);
    step();
    m_hi = 32'h12345678;
    op = OP_MFHI; #1;
    chk("mfhi", RD, 32'h12345678);
    op = OP_MTLO; A = 32'h0BADF00D;
    step();
    m_lo = 32'h0BADF00D;
    op = OP_MFLO; #1;
    chk("mflo", RD, 32'h0BADF00D);
    chk("mthi kept", HI, 32'h12345678);
    op = OP_NONE; #1;
    chk("rd none", RD, 32'd0);

    run_md("divu zero", OP_DIVU, 32'h00001234, 32'd0, 1'b0);
    run_md("div zero", OP_DIV, 32'hFFFF0000, 32'd0, 1'b0);
    run_md("inject", OP_MULT, 32'h00012345, 32'hFFFF8001, 1'b1);

    // Reset during the third busy cycle of a divide.
    start = 1'b1; op = OP_DIV; A = 32'd100; B = 32'd7;
    step();
    start = 1'b0; op = OP_NONE;
    step();
    step();
    chk("mid busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid hi", HI, 32'd0);
    chk("rst mid lo", LO, 32'd0);
    for (int i = 0; i < ND + 2; i++) begin
      step();
      chk("rst no write hi", HI, 32'd0);
      chk("rst no write lo", LO, 32'd0);
      chk("rst no busy", 32'(busy), 32'd0);
    end

    for (int k = 0; k < 30; k++) begin
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) rb = -rb;
      case (sel)
        0: run_md("rnd mult", OP_MULT, ra, rb, 1'b0);
        1: run_md("rnd multu", OP_MULTU, ra, rb, 1'b0);
        2: run_md("rnd div", OP_DIV, ra, rb, 1'b0);
        3: run_md("rnd divu", OP_DIVU, ra, rb, 1'b0);
        4: begin
          op = OP_MTHI; A = ra;
          step();
          op = OP_NONE; m_hi = ra;
          chk("rnd mthi", HI, m_hi);
        end
        5: begin
          op = OP_MTLO; A = ra;
          step();
          op = OP_NONE; m_lo = ra;
          chk("rnd mtlo", LO, m_lo);
        end
        6: begin
          op = OP_MFHI; #1;
          chk("rnd mfhi", RD, m_hi);
          op = OP_NONE;
        end
        default: begin
          op = OP_MFLO; #1;
          chk("rnd mflo", RD, m_lo);
          op = OP_NONE;
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
